// File: rtl/uart_tx_arbiter_if.sv
// Requester / serializer side bundle of the shared UART TX arbiter.
// master drives requests and serializer status, slave is the arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ack;
   logic [7:0]           tx_data;
   logic                 tx_start;
   logic                 tx_busy;
   logic                 grant_valid;
   logic [IW-1:0]        grant_id;

   modport master (
      output req,
      output req_data,
      output req_last,
      output tx_busy,
      input  req_ack,
      input  tx_data,
      input  tx_start,
      input  grant_valid,
      input  grant_id
   );

   modport slave (
      input  req,
      input  req_data,
      input  req_last,
      input  tx_busy,
      output req_ack,
      output tx_data,
      output tx_start,
      output grant_valid,
      output grant_id
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one 8N1 byte serializer
// among NUM_REQ byte sources, with an idle gap after every packet.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BYTES = 16,
   parameter int GAP_CLKS  = 10417
) (
   input  logic            clock,
   input  logic            rst_n,
   uart_tx_arbiter_if.slave bus
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int GW = (GAP_CLKS < 2) ? 1 : $clog2(GAP_CLKS);

   localparam logic [IW:0]    NR      = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0]  LAST_ID = IW'(NUM_REQ - 1);
   localparam logic [8:0]     CAP     = 9'(MAX_BYTES);
   localparam logic [GW-1:0]  GAP_LAST =
      GW'((GAP_CLKS == 0) ? 0 : GAP_CLKS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      HOLD,
      WAIT_DONE,
      GAP
   } state_t;

   state_t state, state_n;

   logic [IW-1:0] owner, owner_n;
   logic [IW-1:0] rr_ptr, rr_n;
   logic [IW-1:0] win, nxt;
   logic [7:0]    byte_cnt, cnt_n;
   logic [8:0]    cnt_p1;
   logic          last_f, last_n;
   logic [GW-1:0] gap_cnt, gap_n;
   logic [IW:0]   idx;
   logic          found;

   logic          sel_req;
   logic          sel_last;
   logic [7:0]    sel_data;

   logic               start_c;
   logic [NUM_REQ-1:0] ack_c;
   logic [7:0]         data_c;
   logic               gv;

   // First requesting index at or after rr_ptr, wrapping.
   always_comb begin
      win   = rr_ptr;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, rr_ptr} + (IW+1)'(i);
         if (idx >= NR) idx = idx - NR;
         if (!found && bus.req[idx[IW-1:0]]) begin
            win   = idx[IW-1:0];
            found = 1'b1;
         end
      end
   end

   assign nxt      = (owner == LAST_ID) ? '0 : owner + 1'b1;
   assign sel_req  = bus.req[owner];
   assign sel_last = bus.req_last[owner];
   assign sel_data = bus.req_data[{owner, 3'b000} +: 8];
   assign cnt_p1   = {1'b0, byte_cnt} + 9'd1;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         byte_cnt <= '0;
         last_f   <= 1'b0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_n;
         owner    <= owner_n;
         rr_ptr   <= rr_n;
         byte_cnt <= cnt_n;
         last_f   <= last_n;
         gap_cnt  <= gap_n;
      end
   end

   always_comb begin
      state_n = state;
      owner_n = owner;
      rr_n    = rr_ptr;
      cnt_n   = byte_cnt;
      last_n  = last_f;
      gap_n   = gap_cnt;
      start_c = 1'b0;
      ack_c   = '0;
      data_c  = '0;
      unique case (state)
         IDLE: begin
            if (|bus.req) begin
               owner_n = win;
               cnt_n   = '0;
               state_n = SEND;
            end
         end
         SEND: begin
            if (!sel_req) begin
               state_n = GAP;
               gap_n   = '0;
               rr_n    = nxt;
            end else if (!bus.tx_busy) begin
               start_c      = 1'b1;
               data_c       = sel_data;
               ack_c[owner] = 1'b1;
               cnt_n        = cnt_p1[7:0];
               last_n       = sel_last | (cnt_p1 == CAP);
               state_n      = HOLD;
            end
         end
         // Serializer is raising busy this cycle; do not trust it.
         HOLD: state_n = WAIT_DONE;
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               if (last_f) begin
                  state_n = GAP;
                  gap_n   = '0;
                  rr_n    = nxt;
               end else begin
                  state_n = SEND;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_n = IDLE;
            else gap_n = gap_cnt + GW'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   assign gv = (state == SEND) ||
               (state == HOLD) ||
               (state == WAIT_DONE);

   assign bus.tx_start    = start_c;
   assign bus.tx_data     = data_c;
   assign bus.req_ack     = ack_c;
   assign bus.grant_valid = gv;
   assign bus.grant_id    = gv ? owner : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-source queues, a serializer model
// and a packet-level round-robin reference.
module tb_uart_tx_arbiter;

   localparam int NR   = 4;
   localparam int MAXB = 4;
   localparam int GAPC = 5;

   typedef struct {
      logic [7:0] d;
      bit         last;
   } byte_t;

   typedef struct {
      int         id;
      logic [7:0] d;
   } ev_t;

   typedef struct packed {
      logic [3:0]  mask;
      logic [31:0] order;
      logic [3:0]  n;
   } vec_t;

   logic clock;
   logic rst_n;

   uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ  (NR),
      .MAX_BYTES(MAXB),
      .GAP_CLKS (GAPC)
   ) dut (
      .clock(clock),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   byte_t q [NR][$];
   ev_t   log_q[$];
   ev_t   exp_q[$];
   int    grants[$];
   int    starts[$];
   int    ack_cnt[NR];
   int    cyc;
   int    busy_cnt;
   int    frame;
   bit    ext_busy;
   bit    rand_frame;
   bit    prev_gv;
   int    errors;
   int    checks;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         bus.req[i] = q[i].size() > 0;
         bus.req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0].d : 8'h00;
         bus.req_last[i] = (q[i].size() > 0) ? q[i][0].last : 1'b0;
      end
      bus.tx_busy = ext_busy || (busy_cnt > 0);
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < NR; i++) s += q[i].size();
      return s;
   endfunction

   task automatic clear_logs();
      log_q.delete();
      grants.delete();
      starts.delete();
      for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
      prev_gv = 1'b0;
   endtask

   // One clock: sample at the falling edge, update sources and
   // the serializer model just after the rising edge.
   task automatic tick();
      logic          st;
      logic [NR-1:0] ak;
      int            gid;
      @(negedge clock);
      cyc++;
      st  = bus.tx_start;
      ak  = bus.req_ack;
      gid = int'(bus.grant_id);
      if (bus.grant_valid && !prev_gv) grants.push_back(gid);
      prev_gv = bus.grant_valid;
      if (st || ak != '0)
         chk("ack_with_start", {27'b0, st, ak},
             {27'b0, 1'b1, 4'b0001 << gid});
      if (st) begin
         chk("tx_data_src", {24'b0, bus.tx_data},
             (q[gid].size() > 0) ? {24'b0, q[gid][0].d} : 32'h1ff);
         log_q.push_back('{gid, bus.tx_data});
         starts.push_back(cyc);
         if (rand_frame) frame = $urandom_range(25, 1);
      end
      for (int i = 0; i < NR; i++) ack_cnt[i] += int'(ak[i]);
      @(posedge clock);
      #1;
      for (int i = 0; i < NR; i++)
         if (ak[i] && q[i].size() > 0) void'(q[i].pop_front());
      if (st) busy_cnt = frame;
      else if (busy_cnt > 0) busy_cnt--;
      drive();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) q[i].delete();
      ext_busy   = 1'b0;
      busy_cnt   = 0;
      frame      = 12;
      rand_frame = 1'b0;
      drive();
      repeat (2) @(posedge clock);
      @(negedge clock);
      rst_n = 1'b1;
      @(posedge clock);
      #1;
      clear_logs();
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (!(pending() == 0 && !bus.grant_valid && busy_cnt == 0)
             && n < budget) begin
         tick();
         n++;
      end
      chk({name, "_done"}, {31'b0, n < budget}, 32'd1);
      repeat (GAPC + 3) tick();
   endtask

   task automatic add_byte(input int id, input logic [7:0] d,
                           input bit last);
      q[id].push_back('{d, last});
   endtask

   // Packet-level round robin: winner sends until its last byte or
   // the cap, then the pointer moves past it.
   task automatic model(input int rr0);
      byte_t m [NR][$];
      byte_t b;
      int    rr;
      int    w;
      int    n;
      rr = rr0;
      exp_q.delete();
      for (int i = 0; i < NR; i++) m[i] = q[i];
      while (1) begin
         w = -1;
         for (int k = 0; k < NR; k++)
            if (w < 0 && m[(rr + k) % NR].size() > 0) w = (rr + k) % NR;
         if (w < 0) break;
         n = 0;
         do begin
            b = m[w].pop_front();
            exp_q.push_back('{w, b.d});
            n++;
         end while (!b.last && n < MAXB && m[w].size() > 0);
         rr = (w + 1) % NR;
      end
   endtask

   task automatic compare_log(input string name);
      chk({name, "_len"}, log_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         chk(name,
             (k < log_q.size()) ?
                32'(log_q[k].id * 256 + int'(log_q[k].d)) : 32'hffff_ffff,
             32'(exp_q[k].id * 256 + int'(exp_q[k].d)));
   endtask

   initial begin
      vec_t        vecs[4];
      int          n;
      bit          held;
      int          occ[NR];
      int          id;
      int          len;
      logic [31:0] g;

      vecs[0] = '{mask: 4'b1111, order: 32'h3210_3210, n: 4'd8};
      vecs[1] = '{mask: 4'b1010, order: 32'h0000_3131, n: 4'd4};
      vecs[2] = '{mask: 4'b0100, order: 32'h0000_0022, n: 4'd2};
      vecs[3] = '{mask: 4'b1001, order: 32'h0000_0303, n: 4'd4};

      errors     = 0;
      checks     = 0;
      cyc        = 0;
      rst_n      = 1'b0;
      ext_busy   = 1'b0;
      busy_cnt   = 0;
      frame      = 12;
      rand_frame = 1'b0;
      prev_gv    = 1'b0;
      drive();
      bus.req = '1;

      // Outputs held low in reset even with every source requesting.
      @(posedge clock);
      #1;
      chk("rst_tx_start", {31'b0, bus.tx_start}, 0);
      chk("rst_req_ack", {28'b0, bus.req_ack}, 0);
      chk("rst_grant_valid", {31'b0, bus.grant_valid}, 0);
      chk("rst_grant_id", {30'b0, bus.grant_id}, 0);
      chk("rst_tx_data", {24'b0, bus.tx_data}, 0);

      // Single 3-byte packet, slow serializer.
      do_reset();
      frame = 100;
      add_byte(0, 8'h41, 1'b0);
      add_byte(0, 8'h42, 1'b0);
      add_byte(0, 8'h43, 1'b1);
      drive();
      tick();
      chk("lat_first_sample", starts.size(), 0);
      tick();
      chk("lat_second_sample", starts.size(), 1);
      wait_idle(2000, "single");
      exp_q.delete();
      exp_q.push_back('{0, 8'h41});
      exp_q.push_back('{0, 8'h42});
      exp_q.push_back('{0, 8'h43});
      compare_log("single");
      chk("single_b2b",
          (starts.size() >= 3) ? 32'(starts[1] - starts[0]) : 32'hffff, 102);
      chk("single_b2b2",
          (starts.size() >= 3) ? 32'(starts[2] - starts[1]) : 32'hffff, 102);
      chk("single_acks", ack_cnt[0], 3);
      chk("single_grants", grants.size(), 1);
      chk("single_released", {31'b0, bus.grant_valid}, 0);
      frame = 12;

      // Round-robin table; pointer carries over between rows.
      do_reset();
      for (int v = 0; v < 4; v++) begin
         clear_logs();
         for (int i = 0; i < NR; i++) begin
            occ[i] = 0;
            if (vecs[v].mask[i]) begin
               add_byte(i, 8'(16 * i + 1), 1'b1);
               add_byte(i, 8'(16 * i + 2), 1'b1);
            end
         end
         drive();
         wait_idle(3000, "rr");
         chk("rr_count", log_q.size(), 32'(vecs[v].n));
         for (int k = 0; k < int'(vecs[v].n); k++) begin
            id = int'(vecs[v].order[4*k +: 4]);
            occ[id]++;
            chk("rr_order",
                (k < log_q.size()) ?
                   32'(log_q[k].id * 256 + int'(log_q[k].d)) : 32'hffff_ffff,
                32'(id * 256 + 16 * id + occ[id]));
         end
      end

      // Cap: long packet from 0 is split around requester 1.
      do_reset();
      for (int k = 0; k < 10; k++) add_byte(0, 8'(8'hA0 + k), k == 9);
      add_byte(1, 8'hB0, 1'b0);
      add_byte(1, 8'hB1, 1'b1);
      model(0);
      drive();
      wait_idle(5000, "cap");
      compare_log("cap");
      g = 0;
      for (int k = 0; k < grants.size(); k++) g = g * 16 + 32'(grants[k]);
      chk("cap_grants", g, 32'h0100);
      chk("cap_resume",
          (log_q.size() > 6) ? {24'b0, log_q[6].d} : 32'hffff, 32'hA4);

      // Abort: requester 1 drops after its second byte starts.
      do_reset();
      for (int k = 0; k < 5; k++) add_byte(1, 8'(8'hC0 + k), k == 4);
      add_byte(2, 8'hD0, 1'b1);
      drive();
      n = 0;
      while (log_q.size() < 2 && n < 500) begin
         tick();
         n++;
      end
      chk("abort_reach", {31'b0, n < 500}, 1);
      tick();
      tick();
      q[1].delete();
      drive();
      held = 1'b1;
      n = 0;
      while (busy_cnt > 0 && n < 100) begin
         tick();
         n++;
         if (!bus.grant_valid) held = 1'b0;
      end
      chk("abort_held", {31'b0, held}, 1);
      wait_idle(1000, "abort");
      chk("abort_len", log_q.size(), 3);
      chk("abort_next",
          (log_q.size() == 3) ?
             32'(log_q[2].id * 256 + int'(log_q[2].d)) : 32'hffff,
          32'h2D0);
      chk("abort_acks1", ack_cnt[1], 2);
      chk("abort_grants", grants.size(), 2);

      // Serializer busy from outside while a byte waits.
      do_reset();
      ext_busy = 1'b1;
      add_byte(3, 8'hE5, 1'b1);
      drive();
      repeat (50) tick();
      chk("hold_none", starts.size(), 0);
      chk("hold_granted", {31'b0, bus.grant_valid}, 1);
      chk("hold_owner", {30'b0, bus.grant_id}, 3);
      ext_busy = 1'b0;
      drive();
      tick();
      tick();
      chk("hold_release", starts.size(), 1);
      repeat (30) tick();
      chk("hold_single", starts.size(), 1);
      chk("hold_acks3", ack_cnt[3], 1);
      wait_idle(500, "hold");

      // Random packets and frame times against the packet model.
      do_reset();
      rand_frame = 1'b1;
      for (int p = 0; p < 30; p++) begin
         id  = $urandom_range(NR - 1, 0);
         len = $urandom_range(7, 1);
         for (int k = 0; k < len; k++)
            add_byte(id, 8'($urandom), k == len - 1);
      end
      model(0);
      drive();
      wait_idle(20000, "rand");
      compare_log("rand");
      rand_frame = 1'b0;
      frame = 12;

      // Reset in WAIT_DONE after the pointer has moved.
      do_reset();
      add_byte(1, 8'h11, 1'b1);
      drive();
      wait_idle(500, "pre_rst");
      add_byte(2, 8'h21, 1'b0);
      add_byte(2, 8'h22, 1'b0);
      add_byte(2, 8'h23, 1'b1);
      drive();
      n = 0;
      while (starts.size() < 2 && n < 500) begin
         tick();
         n++;
      end
      chk("pre_rst_reach", {31'b0, n < 500}, 1);
      repeat (3) tick();
      chk("pre_rst_granted", {31'b0, bus.grant_valid}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_start", {31'b0, bus.tx_start}, 0);
      chk("mid_rst_req_ack", {28'b0, bus.req_ack}, 0);
      chk("mid_rst_grant_valid", {31'b0, bus.grant_valid}, 0);
      for (int i = 0; i < NR; i++) q[i].delete();
      busy_cnt = 0;
      drive();
      @(negedge clock);
      rst_n = 1'b1;
      @(posedge clock);
      #1;
      clear_logs();
      for (int i = 0; i < NR; i++) add_byte(i, 8'(8'h60 + i), 1'b1);
      model(0);
      drive();
      wait_idle(2000, "post_rst");
      chk("post_rst_first",
          (grants.size() > 0) ? 32'(grants[0]) : 32'hffff, 0);
      compare_log("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
